// File: rtl/cpu_mul_pkg.sv
// Shared constants and types for the multiply issue path.
// Both the multiplier and the hazard unit take their depth from MUL_STAGES here.
package cpu_mul_pkg;

    localparam int unsigned MUL_STAGES = 5;
    localparam int unsigned MUL_LAT    = MUL_STAGES + 2;
    localparam int unsigned REG_ID_W   = 5;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned NUM_REGS   = 2 ** REG_ID_W;
    localparam int unsigned CNT_W      = $clog2(MUL_STAGES + 3);

    typedef struct packed {
        logic                valid;
        logic [REG_ID_W-1:0] rd_id;
    } mul_track_t;

    typedef struct packed {
        logic                valid;
        logic [REG_ID_W-1:0] rd_id;
        logic [DATA_W-1:0]   ra_data;
        logic [DATA_W-1:0]   rb_data;
    } mul_issue_t;

endpackage

// File: rtl/cpu_mul_scoreboard.sv
// Busy-register map and in-flight counter for issued multiplies.
// Set marks an issued destination; clear releases it after writeback.
module cpu_mul_scoreboard
    import cpu_mul_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                set_en,
    input  logic [REG_ID_W-1:0] set_id,
    input  logic                clr_en,
    input  logic [REG_ID_W-1:0] clr_id,
    input  logic [REG_ID_W-1:0] look_rd,
    input  logic [REG_ID_W-1:0] look_ra,
    input  logic [REG_ID_W-1:0] look_rb,
    output logic                hit_rd,
    output logic                hit_ra,
    output logic                hit_rb,
    output logic [NUM_REGS-1:0] busy_map,
    output logic [CNT_W-1:0]    inflight_cnt
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // Set and clear never target the same bit: issue requires the bit to be free.
    always_comb begin
        busy_d = busy_q;
        if (set_en) busy_d[set_id] = 1'b1;
        if (clr_en) busy_d[clr_id] = 1'b0;
        cnt_d = cnt_q;
        if (set_en && !clr_en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!set_en && clr_en) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign hit_rd       = busy_q[look_rd];
    assign hit_ra       = busy_q[look_ra];
    assign hit_rb       = busy_q[look_rb];
    assign busy_map     = busy_q;
    assign inflight_cnt = cnt_q;

endmodule

// File: rtl/cpu_mul_issue_ctrl.sv
// Multiply issue controller: hazard-gated issue, writeback tracking and
// arbitration of the shared register-bank write port against the ALU.
module cpu_mul_issue_ctrl
    import cpu_mul_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [REG_ID_W-1:0] req_rd_id,
    input  logic [REG_ID_W-1:0] req_ra_id,
    input  logic [REG_ID_W-1:0] req_rb_id,
    input  logic [DATA_W-1:0]   req_ra_data,
    input  logic [DATA_W-1:0]   req_rb_data,
    input  logic                flush,
    output logic                mul_valid,
    output logic [REG_ID_W-1:0] mul_rd_id,
    output logic [DATA_W-1:0]   mul_ra_data,
    output logic [DATA_W-1:0]   mul_rb_data,
    input  logic                alu_wb_req,
    output logic                alu_wb_stall,
    output logic                retire_valid,
    output logic [REG_ID_W-1:0] retire_rd_id,
    output logic [NUM_REGS-1:0] busy_map,
    output logic [CNT_W-1:0]    inflight_cnt
);

    logic       hit_rd, hit_ra, hit_rb;
    logic       hz;
    logic       issue;
    mul_issue_t iss_q;
    mul_track_t track_q [MUL_LAT];

    assign hz        = hit_rd | hit_ra | hit_rb;
    assign req_ready = !hz && !flush && !reset;
    assign issue     = req_valid && req_ready;

    // Operand registers hold their last value between issues.
    always_ff @(posedge clock) begin
        if (reset) begin
            iss_q <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                track_q[i] <= '0;
            end
        end else begin
            iss_q.valid <= issue;
            if (issue) begin
                iss_q.rd_id   <= req_rd_id;
                iss_q.ra_data <= req_ra_data;
                iss_q.rb_data <= req_rb_data;
            end
            track_q[0] <= '{valid: issue, rd_id: req_rd_id};
            for (int i = 1; i < MUL_LAT; i++) begin
                track_q[i] <= track_q[i-1];
            end
        end
    end

    assign mul_valid    = iss_q.valid;
    assign mul_rd_id    = iss_q.rd_id;
    assign mul_ra_data  = iss_q.ra_data;
    assign mul_rb_data  = iss_q.rb_data;
    assign retire_valid = track_q[MUL_LAT-1].valid;
    assign retire_rd_id = track_q[MUL_LAT-1].rd_id;

    // An issued multiply cannot stall, so the ALU loses the write port.
    assign alu_wb_stall = alu_wb_req & retire_valid;

    cpu_mul_scoreboard u_scoreboard (
        .clock        (clock),
        .reset        (reset),
        .set_en       (issue),
        .set_id       (req_rd_id),
        .clr_en       (retire_valid),
        .clr_id       (retire_rd_id),
        .look_rd      (req_rd_id),
        .look_ra      (req_ra_id),
        .look_rb      (req_rb_id),
        .hit_rd       (hit_rd),
        .hit_ra       (hit_ra),
        .hit_rb       (hit_rb),
        .busy_map     (busy_map),
        .inflight_cnt (inflight_cnt)
    );

endmodule
